// File: rtl/cmp_pkg.sv
// Shared definitions for the sequential magnitude comparator: flag indices,
// FSM state encoding and the flag-word builder.
// Contents: CMP_* flag positions, CMP_FLAGS width, cmp_state_e, cmp_flags().
package cmp_pkg;

   localparam int CMP_FLAGS = 6;

   localparam int CMP_GT = 0;
   localparam int CMP_LT = 1;
   localparam int CMP_GE = 2;
   localparam int CMP_LE = 3;
   localparam int CMP_EQ = 4;
   localparam int CMP_NE = 5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } cmp_state_e;

   // Expands a gt/lt decision into the full flag word. Neither set means the
   // operands were equal.
   function automatic logic [CMP_FLAGS-1:0] cmp_flags(input logic gt, input logic lt);
      logic eq;
      eq = ~(gt | lt);
      cmp_flags         = '0;
      cmp_flags[CMP_GT] = gt;
      cmp_flags[CMP_LT] = lt;
      cmp_flags[CMP_GE] = gt | eq;
      cmp_flags[CMP_LE] = lt | eq;
      cmp_flags[CMP_EQ] = eq;
      cmp_flags[CMP_NE] = ~eq;
   endfunction

endpackage

// File: rtl/Three_State_Logic.sv
// Single-bit tri-state buffer onto a shared bus.
// Latency: combinational. Backpressure: none.
// Ports: a = data in, en = drive enable, y = bus output (z when en = 0).
module Three_State_Logic (
   input  logic a,
   input  logic en,
   output wire  y
);

   assign y = en ? a : 1'bz;

endmodule

// File: rtl/chunk_cmp.sv
// Unsigned compare of one CHUNK-bit slice of each operand.
// Latency: combinational. Backpressure: none.
// Ports: x, y = slices; inv_msb flips both MSBs (offset binary for the signed
// top slice); gt = x > y, lt = x < y.
module chunk_cmp #(
   parameter int CHUNK = 2
) (
   input  logic [CHUNK-1:0] x,
   input  logic [CHUNK-1:0] y,
   input  logic             inv_msb,
   output logic             gt,
   output logic             lt
);

   logic [CHUNK-1:0] msb_mask;
   logic [CHUNK-1:0] xm;
   logic [CHUNK-1:0] ym;

   always_comb begin
      msb_mask          = '0;
      msb_mask[CHUNK-1] = inv_msb;
      xm                = x ^ msb_mask;
      ym                = y ^ msb_mask;
      gt                = (xm > ym);
      lt                = (xm < ym);
   end

endmodule

// File: rtl/seq_magnitude_cmp.sv
// Multi-cycle unsigned/two's-complement magnitude compare, CHUNK bits per cycle, MSB first, early exit.
// Latency: 2 cycles best (top chunk differs) to NCH+1 worst (equal or only chunk 0 differs).
// Backpressure: start accepted only in IDLE/DONE; start during RUN is dropped, not queued.
// Ports: clk, rst_n (async active-low); start/signed_mode/a/b request;
//        en gates flag bus s (tri-state); busy high in RUN; done one-cycle result pulse.
module seq_magnitude_cmp
   import cmp_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CHUNK = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 signed_mode,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 en,
   output logic                 busy,
   output logic                 done,
   output wire  [CMP_FLAGS-1:0] s
);

   localparam int            NCH     = WIDTH / CHUNK;
   localparam int            IW      = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [IW-1:0] TOP_IDX = IW'(NCH - 1);

   if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
      $error("seq_magnitude_cmp: WIDTH must be a multiple of CHUNK");
   end
   if (WIDTH < 2) begin : g_bad_width
      $error("seq_magnitude_cmp: WIDTH must be at least 2");
   end

   cmp_state_e           state_q;
   logic [WIDTH-1:0]     a_q;
   logic [WIDTH-1:0]     b_q;
   logic                 sm_q;
   logic [IW-1:0]        idx_q;
   logic [CMP_FLAGS-1:0] res_q;

   logic [WIDTH-1:0]     a_sh;
   logic [WIDTH-1:0]     b_sh;
   logic [CHUNK-1:0]     a_ch;
   logic [CHUNK-1:0]     b_ch;
   logic                 inv_msb;
   logic                 c_gt;
   logic                 c_lt;
   logic                 accept;

   // Current chunk is brought down to bit 0 by shifting; the top chunk in
   // signed mode is compared offset-binary so the sign needs no extra cycle.
   always_comb begin
      a_sh    = a_q >> (32'(idx_q) * CHUNK);
      b_sh    = b_q >> (32'(idx_q) * CHUNK);
      a_ch    = a_sh[CHUNK-1:0];
      b_ch    = b_sh[CHUNK-1:0];
      inv_msb = sm_q && (idx_q == TOP_IDX);
   end

   chunk_cmp #(
      .CHUNK (CHUNK)
   ) u_chunk_cmp (
      .x       (a_ch),
      .y       (b_ch),
      .inv_msb (inv_msb),
      .gt      (c_gt),
      .lt      (c_lt)
   );

   assign accept = start && (state_q != ST_RUN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sm_q    <= 1'b0;
         idx_q   <= '0;
         res_q   <= '0;
      end else begin
         unique case (state_q)
            ST_IDLE, ST_DONE: begin
               if (accept) begin
                  a_q     <= a;
                  b_q     <= b;
                  sm_q    <= signed_mode;
                  idx_q   <= TOP_IDX;
                  state_q <= ST_RUN;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_RUN: begin
               // First differing chunk decides; reaching chunk 0 equal means eq.
               if (c_gt || c_lt || (idx_q == '0)) begin
                  res_q   <= cmp_flags(c_gt, c_lt);
                  state_q <= ST_DONE;
               end else begin
                  idx_q <= idx_q - IW'(1);
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign busy = (state_q == ST_RUN);
   assign done = (state_q == ST_DONE);

   for (genvar i = 0; i < CMP_FLAGS; i++) begin : g_out
      Three_State_Logic u_tsl (
         .a  (res_q[i]),
         .en (en),
         .y  (s[i])
      );
   end

endmodule

// File: tb/tb_seq_magnitude_cmp.sv
// Self-checking bench for seq_magnitude_cmp (WIDTH=8, CHUNK=2): directed cases
// followed by random compares against an arithmetic reference model.
// Outputs are sampled on the falling clock edge.
module tb_seq_magnitude_cmp;

   localparam int W   = 8;
   localparam int C   = 2;
   localparam int NCH = W / C;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic         signed_mode;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         en;
   logic         busy;
   logic         done;
   wire  [5:0]   s;

   int n_cmp = 0;
   int n_bad = 0;

   seq_magnitude_cmp #(
      .WIDTH (W),
      .CHUNK (C)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .signed_mode (signed_mode),
      .a           (a),
      .b           (b),
      .en          (en),
      .busy        (busy),
      .done        (done),
      .s           (s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no end of test, expected finish before 200000");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input logic [5:0] obs, input logic [5:0] exp, input string tag);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Reference: plain integer compare, chunk count from the highest differing bit.
   task automatic model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic smv,
                        output logic [5:0] f, output int k);
      int ai;
      int bi;
      logic [W-1:0] d;
      if (smv) begin
         ai = $signed(av);
         bi = $signed(bv);
      end else begin
         ai = int'(av);
         bi = int'(bv);
      end
      f[0] = (ai > bi);
      f[1] = (ai < bi);
      f[2] = (ai >= bi);
      f[3] = (ai <= bi);
      f[4] = (ai == bi);
      f[5] = (ai != bi);
      d = av ^ bv;
      k = NCH;
      for (int bit_i = W - 1; bit_i >= 0; bit_i--) begin
         if (d[bit_i]) begin
            k = NCH - (bit_i / C);
            break;
         end
      end
   endtask

   // Entered at the negedge of cycle N+1; leaves at the negedge of the done cycle.
   task automatic expect_run(input logic [5:0] exp_f, input int k, input string tag, input bit poke);
      for (int c = 1; c <= k; c++) begin
         check({4'b0, busy, done}, 6'b000010, {tag, "/run"});
         if (poke && c <= 2) begin
            start       = 1'b1;
            a           = 8'($urandom);
            b           = 8'($urandom);
            signed_mode = 1'($urandom);
         end
         @(negedge clk);
         start = 1'b0;
      end
      check({4'b0, busy, done}, 6'b000001, {tag, "/done"});
      check(s, exp_f, {tag, "/s"});
   endtask

   // Called at a negedge; start is sampled on the following rising edge (N).
   task automatic run_cmp(input logic [W-1:0] av, input logic [W-1:0] bv, input logic smv,
                          input string tag, input bit poke);
      logic [5:0] f;
      int k;
      model(av, bv, smv, f, k);
      a           = av;
      b           = bv;
      signed_mode = smv;
      start       = 1'b1;
      @(negedge clk);
      start       = 1'b0;
      a           = 8'($urandom);
      b           = 8'($urandom);
      signed_mode = 1'($urandom);
      expect_run(f, k, tag, poke);
   endtask

   // A released bus may read as z, or as 0 where z is not carried; a decided
   // result always has at least one flag set, so 0 still means not driven.
   function automatic logic [5:0] released();
      return {5'b0, (s === 6'bzzzzzz) || (s === 6'b000000)};
   endfunction

   initial begin
      rst_n       = 1'b0;
      start       = 1'b0;
      en          = 1'b1;
      a           = '0;
      b           = '0;
      signed_mode = 1'b0;
      repeat (2) @(negedge clk);
      check({4'b0, busy, done}, 6'b000000, "reset/ctl");
      check(s, 6'b000000, "reset/s");
      rst_n = 1'b1;
      @(negedge clk);

      run_cmp(8'hC0, 8'h3F, 1'b0, "u_top_diff", 1'b0);
      check(s, 6'b100101, "u_top_diff/const");
      @(negedge clk);
      check({4'b0, busy, done}, 6'b000000, "u_top_diff/idle");

      run_cmp(8'h5A, 8'h5A, 1'b0, "u_equal", 1'b0);
      check(s, 6'b011100, "u_equal/const");
      @(negedge clk);

      run_cmp(8'hFF, 8'h01, 1'b1, "s_neg", 1'b0);
      check(s, 6'b101010, "s_neg/const");
      run_cmp(8'hFF, 8'h01, 1'b0, "u_ff", 1'b0);
      check(s, 6'b100101, "u_ff/const");
      @(negedge clk);

      // Reset in the middle of a compare.
      a = 8'h01; b = 8'h02; signed_mode = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({4'b0, busy, done}, 6'b000010, "abort/run");
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check({4'b0, busy, done}, 6'b000000, "abort/ctl");
      check(s, 6'b000000, "abort/s");
      @(negedge clk);
      check({4'b0, busy, done}, 6'b000000, "abort/hold");
      rst_n = 1'b1;
      @(negedge clk);
      check({4'b0, busy, done}, 6'b000000, "abort/no_done");
      @(negedge clk);
      run_cmp(8'h01, 8'h02, 1'b0, "post_reset", 1'b0);
      check(s, 6'b101010, "post_reset/const");
      @(negedge clk);

      // start pulses during RUN are ignored, then back-to-back from DONE.
      run_cmp(8'h12, 8'h13, 1'b0, "ignore_start", 1'b1);
      check(s, 6'b101010, "ignore_start/const");
      run_cmp(8'h10, 8'h10, 1'b0, "b2b_eq", 1'b0);
      check(s, 6'b011100, "b2b_eq/const");

      // Output enable only gates the bus.
      en = 1'b0;
      #1;
      check(released(), 6'b000001, "en_off/s");
      @(negedge clk);
      check({4'b0, busy, done}, 6'b000000, "en_off/idle");
      check(released(), 6'b000001, "en_off/s_hold");
      @(negedge clk);
      en = 1'b1;
      #1;
      check(s, 6'b011100, "en_on/s");
      @(negedge clk);

      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 1) == 1) @(negedge clk);
         run_cmp(8'($urandom), (i % 4 == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom),
                 1'($urandom), "random", 1'($urandom));
      end
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
